// File: rtl/qr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qr_pkg : shared sizes, frame length and loader state encoding            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package qr_pkg;

  localparam int DATA_BIT  = 48;
  localparam int ROW_NUM   = 4;
  localparam int COL_NUM   = 4;
  localparam int ADDR_NUM  = 2;
  localparam int H_LEN     = ROW_NUM * COL_NUM;
  localparam int FRAME_LEN = H_LEN + ROW_NUM;
  localparam int BANK_NUM  = COL_NUM + 1;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  typedef logic [CNT_W-1:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qr_input_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qr_input_loader_if : sample stream in, bank write bus out, QR handshake  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface qr_input_loader_if;
  import qr_pkg::*;

  logic                i_valid;
  logic                i_sof;
  logic [DATA_BIT-1:0] i_data;
  logic                o_ready;
  logic [BANK_NUM-1:0] o_we;
  logic [ADDR_NUM-1:0] o_addr;
  logic [DATA_BIT-1:0] o_wdata;
  logic                o_start;
  logic                i_done;
  logic                o_err;

  modport master (
    output i_valid, i_sof, i_data, i_done,
    input  o_ready, o_we, o_addr, o_wdata, o_start, o_err
  );

  modport slave (
    input  i_valid, i_sof, i_data, i_done,
    output o_ready, o_we, o_addr, o_wdata, o_start, o_err
  );

endinterface
`default_nettype wire

// File: rtl/qr_bank_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qr_bank_sel : frame sample index -> one-hot bank select and entry addr   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qr_bank_sel
  import qr_pkg::*;
(
  input  idx_t                idx,
  output logic [BANK_NUM-1:0] we_oh,
  output logic [ADDR_NUM-1:0] addr
);

  idx_t bank;

  // H is column-major, so each group of ROW_NUM samples fills one bank; y follows
  always_comb begin
    if (idx < CNT_W'(H_LEN)) begin
      bank = idx / CNT_W'(ROW_NUM);
      addr = ADDR_NUM'(idx % CNT_W'(ROW_NUM));
    end else begin
      bank = CNT_W'(COL_NUM);
      addr = ADDR_NUM'(idx - CNT_W'(H_LEN));
    end
    we_oh = BANK_NUM'(1) << bank;
  end

endmodule
`default_nettype wire

// File: rtl/qr_input_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qr_input_loader : steers a streamed H/y frame into the QR register banks |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qr_input_loader
  import qr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  qr_input_loader_if.slave bus
);

  state_t              r_state, w_state_nxt;
  idx_t                r_count, w_count_nxt, w_idx;
  logic                w_accept, w_write, w_last;
  logic [BANK_NUM-1:0] w_sel_we, w_we_nxt, r_we;
  logic [ADDR_NUM-1:0] w_sel_addr, w_addr_nxt, r_addr;
  logic [DATA_BIT-1:0] w_wdata_nxt, r_wdata;
  logic                w_start_nxt, r_start, w_err_nxt, r_err;

  assign bus.o_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_accept    = bus.i_valid & bus.o_ready;
  // SOF always restarts at index 0; outside a frame only SOF samples are kept
  assign w_write     = w_accept & (bus.i_sof | (r_state == ST_LOAD));
  assign w_idx       = bus.i_sof ? '0 : r_count;
  assign w_last      = w_write && (w_idx == CNT_W'(FRAME_LEN - 1));

  qr_bank_sel u_bank_sel (
    .idx   (w_idx),
    .we_oh (w_sel_we),
    .addr  (w_sel_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE:  if (w_write) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.i_done) begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_write && !w_last) w_count_nxt = w_idx + CNT_W'(1);
  end

  always_comb begin
    w_we_nxt    = '0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    if (w_write) begin
      w_we_nxt    = w_sel_we;
      w_addr_nxt  = w_sel_addr;
      w_wdata_nxt = bus.i_data;
    end
    w_start_nxt = (r_state == ST_START);
    w_err_nxt   = w_accept & ~w_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_start <= w_start_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.o_we    = r_we;
  assign bus.o_addr  = r_addr;
  assign bus.o_wdata = r_wdata;
  assign bus.o_start = r_start;
  assign bus.o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qr_input_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qr_input_loader : randomized frames checked against a frame model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_qr_input_loader;
  import qr_pkg::*;

  localparam int F  = FRAME_LEN;
  localparam int H  = ROW_NUM * COL_NUM;
  localparam int VW = 1 + BANK_NUM + ADDR_NUM + DATA_BIT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  qr_input_loader_if bus ();
  qr_input_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  logic [DATA_BIT-1:0] sh_bank [BANK_NUM][ROW_NUM];
  logic [DATA_BIT-1:0] frame_d [F];

  // frame-level model: position in frame plus edges elapsed since the last sample
  bit                  m_ready;
  int                  m_n, m_since;
  logic [BANK_NUM-1:0] m_we;
  logic [ADDR_NUM-1:0] m_addr;
  logic [DATA_BIT-1:0] m_wdata;
  bit                  m_start, m_err;

  always @(negedge clk) begin
    if (bus.o_start) start_cnt++;
    if (bus.o_err) err_cnt++;
    for (int b = 0; b < BANK_NUM; b++)
      if (bus.o_we[b]) sh_bank[b][bus.o_addr] = bus.o_wdata;
  end

  function automatic logic [VW-1:0] act_vec();
    return {bus.o_ready, bus.o_we, bus.o_addr, bus.o_wdata, bus.o_start, bus.o_err};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_ready, m_we, m_addr, m_wdata, m_start, m_err};
  endfunction

  function automatic logic [DATA_BIT-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DATA_BIT-1:0];
  endfunction

  task automatic m_reset();
    m_ready = 1'b1; m_n = 0; m_since = 0;
    m_we = '0; m_addr = '0; m_wdata = '0; m_start = 1'b0; m_err = 1'b0;
  endtask

  task automatic tick(input bit v, input bit sof, input logic [DATA_BIT-1:0] d, input bit done);
    int idx, bank, a;
    bus.i_valid = v; bus.i_sof = sof; bus.i_data = d; bus.i_done = done;
    @(posedge clk);
    m_we = '0; m_start = 1'b0; m_err = 1'b0;
    if (m_ready) begin
      if (v) begin
        if (!sof && m_n == 0) m_err = 1'b1;
        else begin
          idx  = sof ? 0 : m_n;
          bank = (idx < H) ? idx / ROW_NUM : COL_NUM;
          a    = (idx < H) ? idx % ROW_NUM : idx - H;
          m_we = BANK_NUM'(1) << bank;
          m_addr = ADDR_NUM'(a);
          m_wdata = d;
          m_n = idx + 1;
          if (m_n == F) begin m_ready = 1'b0; m_since = 0; m_n = 0; end
        end
      end
    end else begin
      m_since++;
      if (m_since == 2) m_start = 1'b1;
      if (m_since >= 3 && done) m_ready = 1'b1;
    end
    #1;
  endtask

  task automatic drive_frame(input string name, input int gap_pct, input bit idx_data);
    int n, guard, s0;
    bit v;
    logic [DATA_BIT-1:0] d;
    n = 0; guard = 0; s0 = start_cnt;
    while (n < F && guard < 2000) begin
      v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      d = idx_data ? DATA_BIT'(n) : rand_data();
      tick(v, v && n == 0, d, (gap_pct > 0) ? 1'($urandom_range(1)) : 1'b0);
      if (v) begin frame_d[n] = d; n++; end
      guard++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s load n=%0d act=%h exp=%h", name, n, act_vec(), exp_vec());
      end
    end
    checks++;
    if (n != F) begin
      failures++;
      $display("FAIL %s timeout accepted=%0d need=%0d", name, n, F);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, rand_data(), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s tail%0d act=%h exp=%h", name, i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL %s start_pulses act=%0d exp=1", name, start_cnt - s0);
    end
    for (int k = 0; k < F; k++) begin
      int b, a;
      b = (k < H) ? k / ROW_NUM : COL_NUM;
      a = (k < H) ? k % ROW_NUM : k - H;
      checks++;
      if (sh_bank[b][a] !== frame_d[k]) begin
        failures++;
        $display("FAIL %s bank%0d[%0d] act=%h exp=%h", name, b, a, sh_bank[b][a], frame_d[k]);
      end
    end
  endtask

  task automatic release_banks(input string name);
    tick(1'b1, 1'b0, rand_data(), 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL %s done act=%h exp=%h", name, act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_data = '0; bus.i_done = 1'b0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state act=%h exp=%h", act_vec(), exp_vec());
    end
    rst_n = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    drive_frame("nominal", 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'($urandom_range(1)), rand_data(), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL backpressure hold%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    release_banks("backpressure");
    drive_frame("backpressure_next", 0, 1'b0);
    release_banks("backpressure_next");
  endtask

  task automatic test_missing_sof();
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, rand_data(), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL missing_sof s%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    tick(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (err_cnt - e0 != 3) begin
      failures++;
      $display("FAIL missing_sof err_pulses act=%0d exp=3", err_cnt - e0);
    end
  endtask

  task automatic test_resync();
    int s0;
    logic [DATA_BIT-1:0] r;
    s0 = start_cnt;
    for (int i = 0; i < 27; i++) begin
      logic [DATA_BIT-1:0] d;
      d = rand_data();
      if (i == 7) r = d;
      tick(1'b1, (i == 0) || (i == 7), d, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL resync s%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL resync tail%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL resync start_pulses act=%0d exp=1", start_cnt - s0);
    end
    checks++;
    if (sh_bank[0][0] !== r) begin
      failures++;
      $display("FAIL resync bank0[0] act=%h exp=%h", sh_bank[0][0], r);
    end
    release_banks("resync");
  endtask

  task automatic test_gapped();
    drive_frame("gapped", 45, 1'b0);
    release_banks("gapped");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, i == 0, rand_data(), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL async_reset load%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset immediate act=%h exp=%h", act_vec(), exp_vec());
    end
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_frame("async_reset_next", 0, 1'b0);
    release_banks("async_reset_next");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_missing_sof();
    test_resync();
    test_gapped();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
